// File: rtl/template_pkg.sv
// Shared types and the block-template artwork used by the block pixel pipeline.
package template_pkg;

  typedef enum logic [1:0] {
    BLACK = 2'd0,
    DARK  = 2'd1,
    LIGHT = 2'd2,
    WHITE = 2'd3
  } template_t;

  // Number of distinct block artworks before the GAMEOVER pattern region.
  localparam int GAMEOVER_REGION = 3;

  typedef enum logic [1:0] {CUR_IDLE, CUR_WIPE, CUR_DONE} curtain_state_t;
  typedef enum logic {FL_IDLE, FL_FLASH} flash_state_t;
  typedef enum logic [1:0] {SEL_ROM, SEL_FLASH, SEL_BLACK} pixel_sel_t;

  // Colour index of one template pixel; regions beyond the artwork set repeat it.
  function automatic int template_pixel(int region, int go_region, int x, int y, int last);
    int  v = 0;
    bit  on_border = (x == 0) || (y == 0) || (x == last) || (y == last);
    if (region == go_region) begin
      v = ((((x >> 2) ^ (y >> 2)) & 1) == 1) ? 2 : 1;
    end else begin
      case (template_t'((region % GAMEOVER_REGION) + 1))
        DARK:    v = on_border ? 1 : 2;
        LIGHT:   v = (x == 0 || y == 0) ? 3 : ((x == last || y == last) ? 1 : 2);
        WHITE:   v = on_border ? 2 : 3;
        default: v = 0;
      endcase
    end
    return v;
  endfunction

endpackage

// File: rtl/block_template_rom.sv
// Synchronous-read template ROM: one word per block row, leftmost pixel in the MSB slice.
module block_template_rom
  import template_pkg::*;
#(
  parameter int BLOCK_PX    = 16,
  parameter int IDX_W       = 2,
  parameter int N_TEMPLATES = 4
) (
  input  logic                                       Clk,
  input  logic [$clog2(N_TEMPLATES*BLOCK_PX)-1:0]    addr,
  output logic [BLOCK_PX*IDX_W-1:0]                  rd_data
);

  localparam int WORD_W = BLOCK_PX * IDX_W;
  localparam int DEPTH  = N_TEMPLATES * BLOCK_PX;

  function automatic logic [WORD_W-1:0] init_word(int a);
    logic [WORD_W-1:0] w = '0;
    for (int x = 0; x < BLOCK_PX; x++) begin
      w[(BLOCK_PX-1-x)*IDX_W +: IDX_W] =
        IDX_W'(template_pixel(a / BLOCK_PX, N_TEMPLATES - 1, x, a % BLOCK_PX, BLOCK_PX - 1));
    end
    return w;
  endfunction

  logic [WORD_W-1:0] rom [DEPTH];

  for (genvar a = 0; a < DEPTH; a++) begin : g_rom
    assign rom[a] = init_word(a);
  end

  // NOTE: the read register carries no reset; it holds constant-table data and a reset
  // would only block mapping onto block RAM / ROM primitives.
  always_ff @(posedge Clk) begin
    rd_data <= rom[addr];
  end

endmodule

// File: rtl/block_pixel_pipeline.sv
// Two-stage block-pixel colour generator with line-clear flash and gameover curtain wipe.
module block_pixel_pipeline
  import template_pkg::*;
#(
  parameter int BLOCK_PX      = 16,
  parameter int IDX_W         = 2,
  parameter int N_TEMPLATES   = 4,
  parameter int BOARD_ROWS    = 20,
  parameter int WIPE_FRAMES   = 2,
  parameter int FLASH_FRAMES  = 4,
  parameter int FLASH_TOGGLES = 6
) (
  input  logic                            Clk,
  input  logic                            Reset,
  input  logic                            frame_start,
  input  logic                            in_valid,
  input  logic [$clog2(N_TEMPLATES)-1:0]  block_template,
  input  logic [$clog2(BLOCK_PX)-1:0]     pixel_x,
  input  logic [$clog2(BLOCK_PX)-1:0]     pixel_y,
  input  logic [$clog2(BOARD_ROWS)-1:0]   board_row,
  input  logic                            flash_row,
  input  logic                            flash_start,
  input  logic                            gameover_start,
  output logic                            out_valid,
  output logic [IDX_W-1:0]                color_index,
  output logic                            flash_active,
  output logic                            flash_done,
  output logic                            gameover_done
);

  localparam int TPL_W     = $clog2(N_TEMPLATES);
  localparam int PX_W      = $clog2(BLOCK_PX);
  localparam int ADDR_W    = $clog2(N_TEMPLATES * BLOCK_PX);
  localparam int WORD_W    = BLOCK_PX * IDX_W;
  localparam int ROW_W     = $clog2(BOARD_ROWS + 1);
  localparam int WCNT_W    = $clog2(WIPE_FRAMES + 1);
  localparam int FCNT_W    = $clog2(FLASH_FRAMES + 1);
  localparam int TCNT_W    = $clog2(FLASH_TOGGLES + 1);
  localparam int GO_REGION = N_TEMPLATES - 1;

  curtain_state_t    cur_state, cur_next;
  logic [ROW_W-1:0]  curtain_row, row_next;
  logic [WCNT_W-1:0] wipe_cnt, wcnt_next;
  flash_state_t      fl_state, fl_next;
  logic              flash_phase, phase_next, done_next, go_begin;
  logic [FCNT_W-1:0] flash_cnt, fcnt_next;
  logic [TCNT_W-1:0] toggle_cnt, tcnt_next;

  logic [TPL_W-1:0]  rom_region;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_data;
  pixel_sel_t        s0_sel, s1_sel;
  logic              s1_valid, curtain_hit;
  logic [PX_W-1:0]   s1_x;
  logic [IDX_W-1:0]  s2_index;

  assign flash_active  = (fl_state == FL_FLASH);
  assign gameover_done = (cur_state == CUR_DONE);
  assign curtain_hit   = (cur_state == CUR_DONE) || (ROW_W'(board_row) < curtain_row);

  // NOTE: every always_comb output gets a default before any branch, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    s0_sel     = SEL_ROM;
    rom_region = TPL_W'(GO_REGION);
    if (curtain_hit) begin
      s0_sel = SEL_ROM;
    end else if (flash_active && flash_phase && flash_row) begin
      s0_sel = SEL_FLASH;
    end else if (block_template == '0) begin
      s0_sel = SEL_BLACK;
    end else begin
      rom_region = block_template - 1'b1;
    end
  end

  assign rom_addr = ADDR_W'(int'(rom_region) * BLOCK_PX + int'(pixel_y));

  block_template_rom #(
    .BLOCK_PX    (BLOCK_PX),
    .IDX_W       (IDX_W),
    .N_TEMPLATES (N_TEMPLATES)
  ) u_rom (
    .Clk     (Clk),
    .addr    (rom_addr),
    .rd_data (rom_data)
  );

  always_comb begin
    s2_index = rom_data[(BLOCK_PX - 1 - int'(s1_x)) * IDX_W +: IDX_W];
    if (s1_sel == SEL_FLASH)      s2_index = '1;
    else if (s1_sel == SEL_BLACK) s2_index = '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      s1_valid    <= 1'b0;
      s1_sel      <= SEL_BLACK;
      s1_x        <= '0;
      out_valid   <= 1'b0;
      color_index <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_sel    <= s0_sel;
      s1_x      <= pixel_x;
      out_valid <= s1_valid;
      if (s1_valid) color_index <= s2_index;
    end
  end

  always_comb begin
    cur_next   = cur_state;
    row_next   = curtain_row;
    wcnt_next  = wipe_cnt;
    fl_next    = fl_state;
    phase_next = flash_phase;
    fcnt_next  = flash_cnt;
    tcnt_next  = toggle_cnt;
    done_next  = 1'b0;
    go_begin   = (cur_state == CUR_IDLE) && gameover_start;

    unique case (cur_state)
      CUR_IDLE: if (gameover_start) begin
        cur_next  = CUR_WIPE;
        row_next  = '0;
        wcnt_next = '0;
      end
      CUR_WIPE: if (frame_start) begin
        if (wipe_cnt == WCNT_W'(WIPE_FRAMES - 1)) begin
          wcnt_next = '0;
          row_next  = curtain_row + 1'b1;
          if (curtain_row == ROW_W'(BOARD_ROWS - 1)) cur_next = CUR_DONE;
        end else begin
          wcnt_next = wipe_cnt + 1'b1;
        end
      end
      default: ;
    endcase

    // A curtain starting this cycle takes precedence over any flash activity.
    unique case (fl_state)
      FL_IDLE: if (flash_start && (cur_state == CUR_IDLE) && !gameover_start) begin
        fl_next    = FL_FLASH;
        phase_next = 1'b1;
        fcnt_next  = '0;
        tcnt_next  = '0;
      end
      FL_FLASH: if (go_begin) begin
        fl_next    = FL_IDLE;
        phase_next = 1'b0;
        fcnt_next  = '0;
        tcnt_next  = '0;
        done_next  = 1'b1;
      end else if (frame_start) begin
        if (flash_cnt == FCNT_W'(FLASH_FRAMES - 1)) begin
          fcnt_next  = '0;
          phase_next = ~flash_phase;
          if (toggle_cnt == TCNT_W'(FLASH_TOGGLES - 1)) begin
            fl_next    = FL_IDLE;
            phase_next = 1'b0;
            tcnt_next  = '0;
            done_next  = 1'b1;
          end else begin
            tcnt_next = toggle_cnt + 1'b1;
          end
        end else begin
          fcnt_next = flash_cnt + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      cur_state   <= CUR_IDLE;
      curtain_row <= '0;
      wipe_cnt    <= '0;
      fl_state    <= FL_IDLE;
      flash_phase <= 1'b0;
      flash_cnt   <= '0;
      toggle_cnt  <= '0;
      flash_done  <= 1'b0;
    end else begin
      cur_state   <= cur_next;
      curtain_row <= row_next;
      wipe_cnt    <= wcnt_next;
      fl_state    <= fl_next;
      flash_phase <= phase_next;
      flash_cnt   <= fcnt_next;
      toggle_cnt  <= tcnt_next;
      flash_done  <= done_next;
    end
  end

endmodule

// File: tb/tb_block_pixel_pipeline.sv
// Directed self-checking bench for block_pixel_pipeline with hand-computed colour indices.
module tb_block_pixel_pipeline;

  logic       Clk, Reset, frame_start, in_valid;
  logic [1:0] block_template;
  logic [3:0] pixel_x, pixel_y;
  logic [4:0] board_row;
  logic       flash_row, flash_start, gameover_start;
  logic       out_valid, flash_active, flash_done, gameover_done;
  logic [1:0] color_index;

  block_pixel_pipeline dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .frame_start    (frame_start),
    .in_valid       (in_valid),
    .block_template (block_template),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .board_row      (board_row),
    .flash_row      (flash_row),
    .flash_start    (flash_start),
    .gameover_start (gameover_start),
    .out_valid      (out_valid),
    .color_index    (color_index),
    .flash_active   (flash_active),
    .flash_done     (flash_done),
    .gameover_done  (gameover_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  typedef struct {
    logic [1:0] tmpl;
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] row;
    logic       frow;
    logic [1:0] exp;
  } vec_t;

  vec_t q[$];

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic add(input int tmpl, input int x, input int y, input int row,
                     input int frow, input int exp);
    vec_t v;
    v.tmpl = 2'(tmpl);
    v.x    = 4'(x);
    v.y    = 4'(y);
    v.row  = 5'(row);
    v.frow = 1'(frow);
    v.exp  = 2'(exp);
    q.push_back(v);
  endtask

  // Streams the queued pixels back to back; output i must appear after the second edge.
  task automatic run_stream(input string tag);
    int n = q.size();
    for (int i = 0; i <= n + 1; i++) begin
      if (i < n) begin
        in_valid       = 1'b1;
        block_template = q[i].tmpl;
        pixel_x        = q[i].x;
        pixel_y        = q[i].y;
        board_row      = q[i].row;
        flash_row      = q[i].frow;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (i == 0) begin
        check({tag, " latency"}, 32'(out_valid), 0);
      end else if (i <= n) begin
        check({tag, " valid"}, 32'(out_valid), 1);
        check({tag, " index"}, 32'(color_index), 32'(q[i-1].exp));
      end else begin
        check({tag, " drain valid"}, 32'(out_valid), 0);
        check({tag, " hold"}, 32'(color_index), 32'(q[n-1].exp));
      end
    end
    q.delete();
  endtask

  task automatic pulse(input logic fs, input logic fl, input logic go);
    frame_start    = fs;
    flash_start    = fl;
    gameover_start = go;
    tick();
    frame_start    = 1'b0;
    flash_start    = 1'b0;
    gameover_start = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; frame_start = 1'b0; in_valid = 1'b0; block_template = '0;
    pixel_x = '0; pixel_y = '0; board_row = '0; flash_row = 1'b0;
    flash_start = 1'b0; gameover_start = 1'b0;
    tick(); tick();
    check("rst out_valid", 32'(out_valid), 0);
    check("rst color", 32'(color_index), 0);
    check("rst flash_active", 32'(flash_active), 0);
    check("rst flash_done", 32'(flash_done), 0);
    check("rst gameover_done", 32'(gameover_done), 0);
    Reset = 1'b0;

    // Template artwork at corners, edges and interiors.
    add(2, 0, 0, 0, 0, 3);  add(1, 15, 13, 0, 0, 1); add(1, 5, 5, 0, 0, 2);
    add(2, 15, 15, 0, 0, 1); add(2, 7, 8, 0, 0, 2);  add(3, 0, 7, 0, 0, 2);
    add(3, 6, 6, 0, 0, 3);  add(0, 6, 6, 0, 0, 0);   add(2, 4, 0, 0, 0, 3);
    run_stream("template");

    for (int y = 0; y < 16; y++)
      for (int x = 0; x < 16; x++) add(0, x, y, y, 0, 0);
    run_stream("black");

    // Flash: phase 1 for frames 0-3, 0 for 4-7, ...; ends on the 24th frame_start.
    pulse(1'b0, 1'b1, 1'b0);
    check("flash active", 32'(flash_active), 1);
    check("flash done idle", 32'(flash_done), 0);
    for (int f = 0; f < 24; f++) begin
      add(1, 5, 5, 3, 1, ((f / 4) % 2 == 0) ? 3 : 2);
      add(1, 5, 5, 3, 0, 2);
      add(0, 1, 1, 3, 1, ((f / 4) % 2 == 0) ? 3 : 0);
      run_stream("flash");
      if (f == 10) begin
        pulse(1'b0, 1'b1, 1'b0);
        check("flash restart ignored", 32'(flash_active), 1);
      end
      pulse(1'b1, 1'b0, 1'b0);
      check("flash done", 32'(flash_done), 32'(f == 23));
      check("flash active run", 32'(flash_active), 32'(f < 23));
    end
    tick();
    check("flash done single", 32'(flash_done), 0);
    add(1, 5, 5, 3, 1, 2);
    run_stream("after flash");

    // Flash start coinciding with frame_start: that frame is not counted.
    pulse(1'b1, 1'b1, 1'b0);
    check("coinc active", 32'(flash_active), 1);
    for (int k = 1; k <= 4; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      add(1, 5, 5, 0, 1, (k < 4) ? 3 : 2);
      run_stream("coinc phase");
    end

    // Gameover mid-flash aborts the flash with a single done pulse.
    pulse(1'b0, 1'b0, 1'b1);
    check("abort active", 32'(flash_active), 0);
    check("abort done", 32'(flash_done), 1);
    tick();
    check("abort done single", 32'(flash_done), 0);
    pulse(1'b0, 1'b1, 1'b0);
    check("flash in wipe ignored", 32'(flash_active), 0);
    pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0);
    add(2, 4, 0, 0, 0, 2); add(2, 4, 0, 1, 0, 3); add(0, 8, 8, 0, 0, 1);
    run_stream("wipe row1");

    // Reset mid-wipe with a pixel in flight.
    in_valid = 1'b1; block_template = 2'd2; pixel_x = '0; pixel_y = '0; board_row = 5'd5;
    tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0; in_valid = 1'b0;
    check("midrst out_valid", 32'(out_valid), 0);
    check("midrst color", 32'(color_index), 0);
    check("midrst gameover_done", 32'(gameover_done), 0);
    check("midrst flash_active", 32'(flash_active), 0);
    pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0);
    add(2, 4, 0, 0, 0, 3);
    run_stream("curtain cleared");

    // Gameover, flash start and frame_start together: curtain wins, frame not counted.
    pulse(1'b1, 1'b1, 1'b1);
    check("tie flash_active", 32'(flash_active), 0);
    check("tie flash_done", 32'(flash_done), 0);
    for (int k = 1; k <= 40; k++) begin
      pulse(1'b1, 1'b0, 1'b0);
      check("gameover_done", 32'(gameover_done), 32'(k == 40));
      if (k == 2) begin
        add(2, 4, 0, 0, 0, 2); add(2, 4, 0, 1, 0, 3);
        run_stream("wipe 2 frames");
      end
      if (k == 39) begin
        add(2, 4, 0, 18, 0, 2); add(2, 4, 0, 19, 0, 3);
        run_stream("wipe 39 frames");
      end
    end
    add(2, 4, 0, 0, 0, 2); add(2, 4, 0, 10, 0, 2); add(2, 4, 0, 19, 0, 2);
    add(0, 0, 0, 7, 0, 1); add(1, 5, 9, 12, 1, 2);
    run_stream("curtain done");
    pulse(1'b0, 1'b0, 1'b1);
    check("restart ignored", 32'(gameover_done), 1);
    pulse(1'b0, 1'b1, 1'b0);
    check("flash in done ignored", 32'(flash_active), 0);
    pulse(1'b1, 1'b0, 1'b0); pulse(1'b1, 1'b0, 1'b0);
    check("done sticky", 32'(gameover_done), 1);
    add(2, 4, 0, 19, 0, 2);
    run_stream("still gameover");

    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check("rst clears done", 32'(gameover_done), 0);
    add(2, 4, 0, 19, 0, 3);
    run_stream("post reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
